// File: rtl/uart_pkg.sv
// Shared UART helpers: bit-period math, ASCII constants, FSM state types.
// Combinational only; no latency or backpressure of its own.
package uart_pkg;

   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RPT_IDLE,
      RPT_LOAD,
      RPT_SEND
   } rpt_state_t;

   function automatic int clks_per_bit(input int clk_freq_mz, input int baud_rate);
      return (clk_freq_mz * 1_000_000) / baud_rate;
   endfunction

   // Digits above 9 are shown as hex letters rather than trapped.
   function automatic logic [7:0] to_ascii(input logic [3:0] v);
      return (v < 4'd10) ? (ASCII_ZERO + {4'd0, v}) : (ASCII_A + {4'd0, v} - 8'd10);
   endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte transmitter; start bit appears the cycle after valid&&ready, each bit lasts CLKS_PER_BIT.
// ready is high only in IDLE; a caller holding valid there gets back-to-back frames with no gap.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       txd
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT - 2);

   tx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   assign ready = (state == TX_IDLE);

   // STOP leaves one cycle early: the IDLE cycle that follows is the last stop-bit
   // cycle, which is where the next byte is accepted without adding an idle cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= TX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         txd     <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: begin
               if (valid) begin
                  state <= TX_START;
                  shreg <= data;
                  cnt   <= '0;
                  txd   <= 1'b0;
               end
            end
            TX_START: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= TX_DATA;
                  txd     <= shreg[0];
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            TX_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {1'b0, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= TX_STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shreg[1];
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            TX_STOP: begin
               if (cnt == STOP_LAST) begin
                  cnt   <= '0;
                  state <= TX_IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bcd_uart_reporter.sv
// Snapshots BCD digits on send and prints them MSD first plus CR LF over 8N1; start bit the cycle after send.
// A send while busy is dropped and flagged on send_dropped one cycle later.
module bcd_uart_reporter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ_MZ = 50,
   parameter int BAUD_RATE   = 115200,
   parameter int BCD_NUM     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [3:0] bcds [BCD_NUM-1:0],
   output logic       uart_txd,
   output logic       busy,
   output logic       send_dropped
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_MZ, BAUD_RATE);
   localparam int MSG_LEN      = BCD_NUM + 2;
   localparam int IW           = $clog2(MSG_LEN + 1);

   typedef logic [IW-1:0] idx_t;

   rpt_state_t state;
   logic [3:0] snap [BCD_NUM-1:0];
   idx_t       char_idx;
   logic [7:0] char_dat;
   logic       char_vld;
   logic [7:0] next_char;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_data;

   assign busy = (state != RPT_IDLE);

   // The first character bypasses the snapshot so its start bit lands the cycle after send.
   assign tx_valid = (state == RPT_IDLE) ? send : ((state == RPT_SEND) && char_vld);
   assign tx_data  = (state == RPT_IDLE) ? to_ascii(bcds[BCD_NUM-1]) : char_dat;

   always_comb begin
      next_char = ASCII_LF;
      if (int'(char_idx) == BCD_NUM)
         next_char = ASCII_CR;
      for (int i = 0; i < BCD_NUM; i++)
         if (int'(char_idx) == BCD_NUM - 1 - i)
            next_char = to_ascii(snap[i]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= RPT_IDLE;
         char_idx     <= '0;
         char_dat     <= '0;
         char_vld     <= 1'b0;
         send_dropped <= 1'b0;
         for (int i = 0; i < BCD_NUM; i++)
            snap[i] <= '0;
      end else begin
         send_dropped <= send && busy;
         case (state)
            RPT_IDLE: begin
               if (send) begin
                  for (int i = 0; i < BCD_NUM; i++)
                     snap[i] <= bcds[i];
                  char_idx <= idx_t'(1);
                  state    <= RPT_LOAD;
               end
            end
            RPT_LOAD: begin
               char_dat <= next_char;
               char_vld <= (int'(char_idx) < MSG_LEN);
               state    <= RPT_SEND;
            end
            RPT_SEND: begin
               // With nothing left to send, tx_ready marks the final stop-bit cycle.
               if (tx_ready) begin
                  if (char_vld) begin
                     char_vld <= 1'b0;
                     char_idx <= char_idx + idx_t'(1);
                     state    <= RPT_LOAD;
                  end else begin
                     char_idx <= '0;
                     state    <= RPT_IDLE;
                  end
               end
            end
            default: state <= RPT_IDLE;
         endcase
      end
   end

   uart_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx (
      .clk  (clk),
      .reset(reset),
      .data (tx_data),
      .valid(tx_valid),
      .ready(tx_ready),
      .txd  (uart_txd)
   );

endmodule

// File: tb/tb_bcd_uart_reporter.sv
// Bench for bcd_uart_reporter: mid-bit line decoder plus a digit-string reference model.
module tb_bcd_uart_reporter;

   localparam int NUM = 8;

   typedef logic [3:0] digits_t [NUM-1:0];

   logic       clk = 1'b0;
   logic       reset;
   logic       send;
   logic [3:0] bcds [NUM-1:0];
   logic       uart_txd;
   logic       busy;
   logic       send_dropped;

   int          vectors = 0;
   int          miscompares = 0;
   byte unsigned rxq[$];
   int          frame_err = 0;
   int          rx_rd = 0;

   always #5 clk = ~clk;

   bcd_uart_reporter #(
      .CLK_FREQ_MZ(1),
      .BAUD_RATE  (100000),
      .BCD_NUM    (NUM)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .send        (send),
      .bcds        (bcds),
      .uart_txd    (uart_txd),
      .busy        (busy),
      .send_dropped(send_dropped)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: digits MSD first as 0-9/A-F, then CR LF.
   function automatic void build_msg(input digits_t d, output byte unsigned m[$]);
      m = {};
      for (int i = NUM - 1; i >= 0; i--) begin
         int v = int'(d[i]);
         m.push_back((v < 10) ? byte'(48 + v) : byte'(65 + v - 10));
      end
      m.push_back(8'd13);
      m.push_back(8'd10);
   endfunction

   // Line decoder: detect start edge, sample at mid-bit.
   initial begin : line_decoder
      byte unsigned b;
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && uart_txd === 1'b0) begin
            repeat (5) @(negedge clk);
            if (uart_txd === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (10) @(negedge clk);
                  b[i] = uart_txd;
               end
               repeat (10) @(negedge clk);
               if (uart_txd !== 1'b1) frame_err++;
               rxq.push_back(b);
            end
         end
      end
   end

   task automatic check_msg(input string tag, input digits_t d, input int fe_base);
      byte unsigned exp[$];
      int n;
      build_msg(d, exp);
      n = rxq.size() - rx_rd;
      check_eq({tag, "_len"}, n, exp.size());
      for (int i = 0; i < exp.size(); i++)
         check_eq($sformatf("%s_ch%0d", tag, i),
                  (i < n) ? 32'(rxq[rx_rd + i]) : 32'hFFFF_FFFF, exp[i]);
      check_eq({tag, "_frame"}, frame_err - fe_base, 0);
      rx_rd = rxq.size();
   endtask

   task automatic start_report(input digits_t d);
      @(negedge clk);
      bcds = d;
      send = 1'b1;
   endtask

   // Cycle c=1 is the cycle after send was accepted.
   task automatic run_report(input int chg_at, input int dup_at, input int rst_at, input bit chain,
                             output int busy_cycles, output int drops);
      busy_cycles = 0;
      drops = 0;
      for (int c = 1; c <= 1500; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check_eq("start_busy", busy, 1);
            check_eq("start_bit", uart_txd, 0);
         end
         if (rst_at > 0 && c == rst_at + 1) begin
            check_eq("rst_txd", uart_txd, 1);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_drop", send_dropped, 0);
            reset = 1'b0;
            return;
         end
         if (send_dropped) drops++;
         send = (c == dup_at);
         if (c == chg_at)
            for (int i = 0; i < NUM; i++) bcds[i] = 4'd9;
         if (c == rst_at) reset = 1'b1;
         if (!busy) begin
            send = chain;
            return;
         end
         busy_cycles++;
      end
      send = 1'b0;
   endtask

   initial begin : main
      digits_t d, d2;
      int bc, dr, fe, idle_ok;

      reset = 1'b1;
      send  = 1'b0;
      for (int i = 0; i < NUM; i++) bcds[i] = 4'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("reset_txd", uart_txd, 1);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_drop", send_dropped, 0);
      reset = 1'b0;

      idle_ok = 0;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (uart_txd === 1'b1 && busy === 1'b0) idle_ok++;
      end
      check_eq("idle_cycles", idle_ok, 2000);

      for (int i = 0; i < NUM; i++) d[i] = 4'(i + 1);
      fe = frame_err;
      start_report(d);
      run_report(0, 0, 0, 1'b0, bc, dr);
      check_eq("seq_busy_len", bc, 1000);
      check_eq("seq_drops", dr, 0);
      check_msg("seq", d, fe);

      fe = frame_err;
      start_report(d);
      run_report(50, 300, 0, 1'b0, bc, dr);
      check_eq("snap_busy_len", bc, 1000);
      check_eq("snap_drops", dr, 1);
      check_msg("snap", d, fe);

      for (int i = 0; i < NUM; i++) d[i] = 4'd0;
      d[0] = 4'd10;
      d[1] = 4'd15;
      fe = frame_err;
      start_report(d);
      run_report(0, 0, 0, 1'b0, bc, dr);
      check_msg("hex", d, fe);

      for (int i = 0; i < NUM; i++) d[i] = 4'($urandom_range(0, 15));
      start_report(d);
      run_report(0, 0, 455, 1'b0, bc, dr);
      repeat (150) @(negedge clk);
      rx_rd = rxq.size();
      check_eq("post_rst_idle", busy, 0);
      for (int i = 0; i < NUM; i++) d[i] = 4'($urandom_range(0, 15));
      fe = frame_err;
      start_report(d);
      run_report(0, 0, 0, 1'b0, bc, dr);
      check_eq("post_rst_busy_len", bc, 1000);
      check_msg("post_rst", d, fe);

      for (int i = 0; i < NUM; i++) d[i] = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM; i++) d2[i] = 4'($urandom_range(0, 15));
      fe = frame_err;
      start_report(d);
      run_report(0, 0, 0, 1'b1, bc, dr);
      check_eq("b2b1_busy_len", bc, 1000);
      check_msg("b2b1", d, fe);
      bcds = d2;
      fe = frame_err;
      run_report(0, 0, 0, 1'b0, bc, dr);
      check_eq("b2b2_busy_len", bc, 1000);
      check_msg("b2b2", d2, fe);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < NUM; i++) d[i] = 4'($urandom_range(0, 15));
         fe = frame_err;
         start_report(d);
         run_report(0, 0, 0, 1'b0, bc, dr);
         check_eq($sformatf("rnd%0d_busy_len", r), bc, 1000);
         check_msg($sformatf("rnd%0d", r), d, fe);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
